axi4_slave_mem: RTL



---
 rtl/axi4_pkg.sv | 7 +
 rtl/axi4_addr_gen.sv | 26 ++
 rtl/axi4_slave_mem.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared burst/response encodings and FSM state types for the AXI4 slave memory
package axi4_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
endpackage

// File: rtl/axi4_addr_gen.sv
// axi4_addr_gen: next beat address for FIXED/INCR/WRAP bursts plus burst-legality flag
module axi4_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next,
  output logic                  err
);
  localparam int LG = $clog2(DATA_WIDTH / 8);
  logic [ADDR_WIDTH-1:0] sz, total, step, lower;
  always_comb begin
    sz    = ADDR_WIDTH'(1) << size;
    total = sz * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    step  = (addr & ~(sz - ADDR_WIDTH'(1))) + sz;
    lower = addr & ~(total - ADDR_WIDTH'(1));
    next  = burst == INCR ? step : burst == WRAP ? (step == lower + total ? lower : step) : addr;
    err   = burst == 2'b11 || size > 3'(LG) ||
            (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end
endmodule

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: memory-backed AXI4 slave with independent write and read burst engines
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [1:0]              AWBURST,
  input  logic [2:0]              AWSIZE,
  input  logic [7:0]              AWLEN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [1:0]              ARBURST,
  input  logic [2:0]              ARSIZE,
  input  logic [7:0]              ARLEN,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int LG = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  wr_state_e ws;
  rd_state_e rs;
  logic [ADDR_WIDTH-1:0] waddr, wnext, raddr, rnext, ga;
  logic [7:0] wlen, wcnt, rlen, rcnt, glen;
  logic [2:0] wsize, rsize, gsize;
  logic [1:0] wburst, rburst, gburst, rresp_n;
  logic werr, wgerr, rgerr, win, rin, wbeat, wfinal, beat_err;
  logic [DATA_WIDTH-1:0] rword;
  axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wgen (
    .addr(waddr), .size(wsize), .len(wlen), .burst(wburst), .next(wnext), .err(wgerr)
  );
  // While idle the read generator looks at the AR channel so the first beat is fetched on the handshake
  axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rgen (
    .addr(ga), .size(gsize), .len(glen), .burst(gburst), .next(rnext), .err(rgerr)
  );
  always_comb begin
    ga       = rs == R_IDLE ? ARADDR : raddr;
    gsize    = rs == R_IDLE ? ARSIZE : rsize;
    glen     = rs == R_IDLE ? ARLEN : rlen;
    gburst   = rs == R_IDLE ? ARBURST : rburst;
    win      = (waddr >> LG) < ADDR_WIDTH'(MEM_DEPTH);
    rin      = (ga >> LG) < ADDR_WIDTH'(MEM_DEPTH);
    wbeat    = ws == W_DATA && WVALID && WREADY;
    wfinal   = wcnt == wlen;
    beat_err = !win || (WLAST != wfinal);
    rword    = rin ? mem[ga[LG+:IW]] : '0;
    rresp_n  = (!rin || rgerr) ? SLVERR : OKAY;
  end
  always_ff @(posedge ACLK)
    if (wbeat && win)
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (WSTRB[b]) mem[waddr[LG+:IW]][8*b+:8] <= WDATA[8*b+:8];
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      ws <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY <= 1'b0;
      BVALID <= 1'b0;
      BRESP <= OKAY;
      waddr <= '0;
      wlen <= '0;
      wsize <= '0;
      wburst <= '0;
      wcnt <= '0;
      werr <= 1'b0;
    end else
      case (ws)
        W_IDLE:
          if (AWVALID && AWREADY) begin
            waddr <= AWADDR;
            wlen <= AWLEN;
            wsize <= AWSIZE;
            wburst <= AWBURST;
            wcnt <= '0;
            werr <= 1'b0;
            AWREADY <= 1'b0;
            WREADY <= 1'b1;
            ws <= W_DATA;
          end else AWREADY <= 1'b1;
        W_DATA:
          if (wbeat) begin
            werr <= werr || beat_err;
            if (wfinal) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP <= (werr || beat_err || wgerr) ? SLVERR : OKAY;
              ws <= W_RESP;
            end else begin
              waddr <= wnext;
              wcnt <= wcnt + 8'd1;
            end
          end
        default:
          if (BREADY) begin
            BVALID <= 1'b0;
            BRESP <= OKAY;
            AWREADY <= 1'b1;
            ws <= W_IDLE;
          end
      endcase
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      rs <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID <= 1'b0;
      RLAST <= 1'b0;
      RDATA <= '0;
      RRESP <= OKAY;
      raddr <= '0;
      rlen <= '0;
      rsize <= '0;
      rburst <= '0;
      rcnt <= '0;
    end else
      case (rs)
        R_IDLE:
          if (ARVALID && ARREADY) begin
            raddr <= rnext;
            rlen <= ARLEN;
            rsize <= ARSIZE;
            rburst <= ARBURST;
            rcnt <= '0;
            RDATA <= rword;
            RRESP <= rresp_n;
            RLAST <= ARLEN == 8'd0;
            RVALID <= 1'b1;
            ARREADY <= 1'b0;
            rs <= R_DATA;
          end else ARREADY <= 1'b1;
        default:
          if (RREADY) begin
            if (RLAST) begin
              RVALID <= 1'b0;
              RLAST <= 1'b0;
              ARREADY <= 1'b1;
              rs <= R_IDLE;
            end else begin
              raddr <= rnext;
              rcnt <= rcnt + 8'd1;
              RDATA <= rword;
              RRESP <= rresp_n;
              RLAST <= rcnt + 8'd1 == rlen;
            end
          end
      endcase
endmodule
